// File: rtl/aes_dec_sched_pkg.sv
// Shared types and constants for the AES decipher request scheduler.
package aes_dec_sched_pkg;

  // Scheduler FSM states
  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    RESP
  } state_t;

  // Key length encodings carried on reqN_keylen / eng_keylen
  localparam logic AES_128_BIT_KEY = 1'b0;
  localparam logic AES_256_BIT_KEY = 1'b1;

  // Width of the optional engine watchdog counter
  localparam int WD_W = 8;

endpackage

// File: rtl/aes_dec_sched_arb.sv
// Two-way round-robin arbiter for the AES decipher scheduler.
// Grant is combinational from the valids; the priority pointer moves only
// when the scheduler retires a request (update strobe).
module aes_dec_rr_arb2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       valid0,
  input  logic       valid1,
  input  logic       update,
  input  logic       served_id,
  output logic [1:0] grant
);

  logic prio1;  // requester 1 wins a tie

  // Priority moves to the requester that was not just served
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) prio1 <= 1'b0;
    else if (update) prio1 <= ~served_id;
  end

  // One-hot grant: tie goes to the priority holder, otherwise the lone valid
  always_comb begin
    // NOTE: default first so no path leaves grant unassigned (no latch).
    grant = 2'b00;
    if (valid0 && valid1) grant = prio1 ? 2'b10 : 2'b01;
    else if (valid0)      grant = 2'b01;
    else if (valid1)      grant = 2'b10;
  end

endmodule

// File: rtl/aes_dec_sched.sv
// Scheduler that arbitrates two decrypt requesters onto one AES decipher
// engine and returns the plaintext on a single response channel.
// Optional feature: define AES_DEC_SCHED_TIMEOUT_EN to add an engine
// watchdog that aborts a request after TIMEOUT_CYCLES waiting cycles.
module aes_dec_sched
  import aes_dec_sched_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [127:0] req0_block,
  input  logic         req0_keylen,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [127:0] req1_block,
  input  logic         req1_keylen,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [127:0] rsp_block,
  output logic         rsp_err,
  output logic         eng_next,
  output logic         eng_keylen,
  output logic [127:0] eng_block,
  input  logic [127:0] eng_new_block,
  input  logic         eng_ready,
  output logic         busy
);

  // The watchdog counter is 8 bits wide, so the limit must fit in it
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  state_t     state, state_nxt;
  logic [1:0] grant;
  logic       handshake;
  logic       eng_done;
  logic       rsp_accept;
  logic       timeout;

  aes_dec_rr_arb2 u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .valid0    (req0_valid),
    .valid1    (req1_valid),
    .update    (rsp_accept),
    .served_id (rsp_id),
    .grant     (grant)
  );

  // Ready only in IDLE and never while reset is held
  assign req0_ready = reset_n && (state == IDLE) && grant[0];
  assign req1_ready = reset_n && (state == IDLE) && grant[1];
  assign handshake  = (state == IDLE) && (grant != 2'b00);
  assign eng_done   = (state == WAIT_DONE) && eng_ready;
  assign rsp_accept = (state == RESP) && rsp_ready;
  assign eng_next   = (state == START);
  assign busy       = (state != IDLE);

`ifdef AES_DEC_SCHED_TIMEOUT_EN
  logic [WD_W-1:0] wd_cnt;
  logic            in_wait;

  assign in_wait = (state == WAIT_BUSY) || (state == WAIT_DONE);
  // Fires on the last permitted waiting cycle; a normal completion in the same cycle wins
  assign timeout = in_wait && !eng_done && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  // Watchdog: cleared when a request is accepted, counts waiting cycles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       wd_cnt <= '0;
    else if (handshake) wd_cnt <= '0;
    else if (in_wait)   wd_cnt <= wd_cnt + 1'b1;
  end

  // Error flag travels with the response it describes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        rsp_err <= 1'b0;
    else if (eng_done)   rsp_err <= 1'b0;
    else if (timeout)    rsp_err <= 1'b1;
    else if (rsp_accept) rsp_err <= 1'b0;
  end
`else
  assign timeout = 1'b0;
  assign rsp_err = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (handshake) state_nxt = START;
      START:     state_nxt = WAIT_BUSY;
      WAIT_BUSY: if (timeout) state_nxt = RESP;
                 else if (!eng_ready) state_nxt = WAIT_DONE;
      WAIT_DONE: if (eng_ready || timeout) state_nxt = RESP;
      RESP:      if (rsp_ready) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Request capture toward the engine and response capture from it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      eng_block  <= '0;
      eng_keylen <= AES_128_BIT_KEY;
      rsp_id     <= 1'b0;
      rsp_block  <= '0;
      rsp_valid  <= 1'b0;
    end else begin
      if (handshake) begin
        eng_block  <= grant[1] ? req1_block  : req0_block;
        eng_keylen <= grant[1] ? req1_keylen : req0_keylen;
        rsp_id     <= grant[1];
      end
      if (eng_done) begin
        rsp_block <= eng_new_block;
        rsp_valid <= 1'b1;
      end else if (timeout) begin
        rsp_block <= '0;
        rsp_valid <= 1'b1;
      end else if (rsp_accept) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aes_dec_sched.sv
// Self-checking bench for aes_dec_sched with a behavioural decipher engine.
// Build with AES_DEC_SCHED_TIMEOUT_EN defined to also exercise the watchdog.
module tb_aes_dec_sched;
  import aes_dec_sched_pkg::*;

  localparam int TO = 64;
  localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_C3 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         req0_valid, req0_ready, req0_keylen;
  logic         req1_valid, req1_ready, req1_keylen;
  logic [127:0] req0_block, req1_block;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [127:0] rsp_block;
  logic         eng_next, eng_keylen, eng_ready;
  logic [127:0] eng_block, eng_new_block;
  logic         busy;

  int checks = 0;
  int failures = 0;
  int rr_last = 1;      // model: requester served last (1 => requester 0 has priority)
  int eng_lat = 3;      // cycles the engine holds eng_ready low
  bit eng_stuck = 1'b0; // engine ignores eng_next, eng_ready stays 1
  int next_cnt = 0;     // eng_next pulses seen
  int eng_cnt;
  logic [127:0] eng_res, cap_blk;
  logic         cap_kl;

  always #5 clk = ~clk;

  aes_dec_sched #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_block(req0_block), .req0_keylen(req0_keylen),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_block(req1_block), .req1_keylen(req1_keylen),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_block(rsp_block), .rsp_err(rsp_err),
    .eng_next(eng_next), .eng_keylen(eng_keylen), .eng_block(eng_block),
    .eng_new_block(eng_new_block), .eng_ready(eng_ready), .busy(busy)
  );

  // Decipher reference: FIPS-197 vectors exactly, other blocks via a fixed keyed scramble
  function automatic logic [127:0] eng_func(input logic [127:0] b, input logic kl);
    if (b == CT_C1 && kl == AES_128_BIT_KEY) return PT;
    if (b == CT_C3 && kl == AES_256_BIT_KEY) return PT;
    return {b[63:0], b[127:64]} ^ (kl ? {4{32'h5a5ac3c3}} : {4{32'h0f1e2d3c}});
  endfunction

  function automatic logic [127:0] rand_block();
    return {$urandom, $urandom, $urandom, $urandom} | 128'h1;
  endfunction

  // Behavioural engine: busy for eng_lat cycles after eng_next, then presents the result
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      eng_ready     <= 1'b1;
      eng_cnt       <= 0;
      eng_new_block <= {4{32'hdeadbeef}};
    end else if (eng_stuck) begin
      eng_ready <= 1'b1;
    end else if (eng_next) begin
      eng_ready     <= 1'b0;
      eng_cnt       <= eng_lat;
      eng_res       <= eng_func(eng_block, eng_keylen);
      cap_blk       <= eng_block;
      cap_kl        <= eng_keylen;
      eng_new_block <= {4{32'hbad0bad0}};
    end else if (eng_cnt > 1) begin
      eng_cnt <= eng_cnt - 1;
    end else if (eng_cnt == 1) begin
      eng_cnt       <= 0;
      eng_ready     <= 1'b1;
      eng_new_block <= eng_res;
    end
  end

  // Continuous checks: engine inputs held while it works, no ready outside IDLE
  initial forever begin
    @(negedge clk);
    if (eng_next) next_cnt++;
    if (reset_n && eng_cnt != 0) begin
      checks++;
      if (eng_block !== cap_blk || eng_keylen !== cap_kl) begin
        failures++;
        $display("FAIL eng_hold: eng_block=%h kl=%b, required %h kl=%b", eng_block, eng_keylen, cap_blk, cap_kl);
      end
    end
    if (reset_n && busy) begin
      checks++;
      if (req0_ready || req1_ready) begin
        failures++;
        $display("FAIL ready_outside_idle: req0_ready=%b req1_ready=%b, required 0 0", req0_ready, req1_ready);
      end
    end
  end

  // Wait (bounded) until a requester is granted; gid = -1 on timeout
  task automatic wait_grant(output int gid);
    int t = 0;
    #1;
    while (!(req0_ready || req1_ready) && t < 200) begin
      @(negedge clk); #1; t++;
    end
    checks++;
    if (!(req0_ready || req1_ready)) begin
      failures++; gid = -1;
      $display("FAIL grant_timeout: no reqN_ready within 200 cycles");
    end else gid = req1_ready ? 1 : 0;
  endtask

  // Wait (bounded) for rsp_valid; lat counts cycles from the handshake cycle
  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 300);
    checks++;
    if (!rsp_valid) begin
      failures++;
      $display("FAIL rsp_timeout: rsp_valid=0 after %0d cycles, required 1", lat);
    end
  endtask

  task automatic accept();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL rsp_clear: rsp_valid=%b after accept, required 0", rsp_valid);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({busy, rsp_valid, rsp_id, rsp_err, eng_next, eng_keylen, req0_ready, req1_ready} !== 8'h00 ||
        rsp_block !== '0 || eng_block !== '0) begin
      failures++;
      $display("FAIL reset_outputs: busy=%b rsp_valid=%b rsp_block=%h eng_block=%h, required all 0",
               busy, rsp_valid, rsp_block, eng_block);
    end
    @(negedge clk); reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: busy=%b rsp_valid=%b, required 0 0", busy, rsp_valid);
    end
  endtask

  task automatic test_fips();
    int gid, lat;
    for (int r = 0; r < 2; r++) begin
      eng_lat = $urandom_range(1, 6);
      if (r == 0) begin
        req0_block = CT_C1; req0_keylen = AES_128_BIT_KEY; req0_valid = 1'b1;
      end else begin
        req1_block = CT_C3; req1_keylen = AES_256_BIT_KEY; req1_valid = 1'b1;
      end
      wait_grant(gid);
      checks++;
      if (gid !== r) begin failures++; $display("FAIL fips_grant%0d: got %0d, required %0d", r, gid, r); end
      wait_rsp(lat);
      req0_valid = 1'b0; req1_valid = 1'b0;
      checks++;
      if (rsp_block !== PT || rsp_id !== r[0] || rsp_err !== 1'b0) begin
        failures++;
        $display("FAIL fips_rsp%0d: block=%h id=%b err=%b, required %h id=%0d err=0", r, rsp_block, rsp_id, rsp_err, PT, r);
      end
      checks++;
      if (lat != eng_lat + 3) begin
        failures++;
        $display("FAIL fips_latency%0d: %0d cycles, required %0d", r, lat, eng_lat + 3);
      end
      accept();
      rr_last = r;
    end
  endtask

  task automatic test_round_robin();
    int gid, lat, exp_id;
    logic [127:0] blk [2];
    logic         kl  [2];
    logic [127:0] exp_blk;
    for (int i = 0; i < 2; i++) begin blk[i] = rand_block(); kl[i] = 1'($urandom_range(0, 1)); end
    req0_block = blk[0]; req0_keylen = kl[0]; req1_block = blk[1]; req1_keylen = kl[1];
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      eng_lat = $urandom_range(1, 6);
      exp_id  = 1 - rr_last;
      exp_blk = eng_func(blk[exp_id], kl[exp_id]);
      wait_grant(gid);
      checks++;
      if (gid != exp_id) begin failures++; $display("FAIL rr_grant%0d: got %0d, required %0d", k, gid, exp_id); end
      wait_rsp(lat);
      blk[exp_id] = rand_block(); kl[exp_id] = 1'($urandom_range(0, 1));
      if (exp_id == 0) begin req0_block = blk[0]; req0_keylen = kl[0]; end
      else             begin req1_block = blk[1]; req1_keylen = kl[1]; end
      checks++;
      if (rsp_id !== exp_id[0] || rsp_block !== exp_blk || rsp_err !== 1'b0) begin
        failures++;
        $display("FAIL rr_rsp%0d: id=%b block=%h err=%b, required id=%0d %h err=0", k, rsp_id, rsp_block, rsp_err, exp_id, exp_blk);
      end
      rr_last = exp_id;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk); rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int gid, lat, exp_id, n0;
    logic [127:0] exp_blk;
    req0_block = rand_block(); req0_keylen = 1'($urandom_range(0, 1));
    req1_block = rand_block(); req1_keylen = 1'($urandom_range(0, 1));
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b0;
    n0 = next_cnt;
    for (int k = 0; k < 2; k++) begin
      eng_lat = $urandom_range(1, 6);
      exp_id  = 1 - rr_last;
      exp_blk = (exp_id == 0) ? eng_func(req0_block, req0_keylen) : eng_func(req1_block, req1_keylen);
      wait_grant(gid);
      checks++;
      if (gid != exp_id) begin failures++; $display("FAIL bp_grant%0d: got %0d, required %0d", k, gid, exp_id); end
      wait_rsp(lat);
      for (int c = 0; c < 10; c++) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_block !== exp_blk || rsp_id !== exp_id[0]) begin
          failures++;
          $display("FAIL bp_hold%0d_c%0d: valid=%b block=%h id=%b, required 1 %h %0d", k, c, rsp_valid, rsp_block, rsp_id, exp_blk, exp_id);
        end
        @(negedge clk);
      end
      checks++;
      if (next_cnt - n0 != k + 1) begin
        failures++;
        $display("FAIL bp_eng_next%0d: %0d pulses, required %0d", k, next_cnt - n0, k + 1);
      end
      if (exp_id == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
      accept();
      rr_last = exp_id;
    end
  endtask

  task automatic test_reset_mid();
    int gid, lat;
    logic [127:0] exp_blk;
    eng_lat = 6;
    req1_block = rand_block(); req1_keylen = AES_256_BIT_KEY; req1_valid = 1'b1;
    wait_grant(gid);
    repeat (3) @(negedge clk);
    req1_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || eng_block !== req1_block) begin
      failures++;
      $display("FAIL rm_inflight: busy=%b eng_block=%h, required 1 %h", busy, eng_block, req1_block);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, rsp_valid, rsp_id, rsp_err, eng_next, eng_keylen, req0_ready, req1_ready} !== 8'h00 ||
        rsp_block !== '0 || eng_block !== '0) begin
      failures++;
      $display("FAIL rm_outputs: busy=%b rsp_valid=%b rsp_id=%b rsp_block=%h eng_block=%h, required all 0",
               busy, rsp_valid, rsp_id, rsp_block, eng_block);
    end
    rr_last = 1;
    @(negedge clk); reset_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL rm_no_rsp_c%0d: rsp_valid=%b busy=%b, required 0 0", c, rsp_valid, busy);
      end
    end
    eng_lat = $urandom_range(1, 6);
    req0_block = rand_block(); req0_keylen = AES_128_BIT_KEY;
    req1_block = rand_block(); req1_keylen = AES_256_BIT_KEY;
    req0_valid = 1'b1; req1_valid = 1'b1;
    exp_blk = eng_func(req0_block, req0_keylen);
    wait_grant(gid);
    checks++;
    if (gid != 0) begin failures++; $display("FAIL rm_prio: got %0d, required 0", gid); end
    wait_rsp(lat);
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++;
    if (rsp_block !== exp_blk || rsp_id !== 1'b0 || lat != eng_lat + 3) begin
      failures++;
      $display("FAIL rm_after: block=%h id=%b lat=%0d, required %h 0 %0d", rsp_block, rsp_id, lat, exp_blk, eng_lat + 3);
    end
    accept();
    rr_last = 0;
  endtask

`ifdef AES_DEC_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    int gid, lat;
    eng_stuck = 1'b1;
    req0_block = rand_block(); req0_keylen = AES_128_BIT_KEY; req0_valid = 1'b1;
    wait_grant(gid);
    wait_rsp(lat);
    req0_valid = 1'b0;
    // waiting starts two cycles after the handshake cycle, then TO waiting cycles elapse
    checks++;
    if (rsp_err !== 1'b1 || rsp_block !== '0 || rsp_id !== 1'b0 || lat != TO + 2) begin
      failures++;
      $display("FAIL timeout_rsp: err=%b block=%h id=%b lat=%0d, required 1 0 0 %0d", rsp_err, rsp_block, rsp_id, lat, TO + 2);
    end
    accept();
    rr_last = 0;
    eng_stuck = 1'b0;
  endtask
`endif

  initial begin
    reset_n = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_block = '0; req0_keylen = 1'b0;
    req1_valid = 1'b0; req1_block = '0; req1_keylen = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_fips();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
`ifdef AES_DEC_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_dec_sched.md
AES_DEC_SCHED -- requirements
Module: aes_dec_sched

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 64, the engine watchdog limit in cycles (used only when AES_DEC_SCHED_TIMEOUT_EN is defined).
REQ-002 The block SHALL have port clk  input  1  the single clock; all state is on its rising edge.
REQ-003 The block SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have ports req0_valid / req1_valid  input  1  requester N has a block to decrypt.
REQ-005 The block SHALL have ports req0_ready / req1_ready  output  1  requester N's request is accepted this cycle.
REQ-006 The block SHALL have ports req0_block / req1_block  input  128  ciphertext, and ports req0_keylen / req1_keylen  input  1  key length (0 = AES-128, 1 = AES-256).
REQ-007 The block SHALL have ports rsp_valid  output  1, rsp_ready  input  1, rsp_id  output  1 (requester index), rsp_block  output  128 (plaintext) and rsp_err  output  1 (watchdog abort).
REQ-008 The block SHALL have engine ports eng_next  output  1, eng_keylen  output  1, eng_block  output  128, eng_new_block  input  128 and eng_ready  input  1.
REQ-009 The block SHALL have port busy  output  1, high whenever the FSM is not in IDLE.
REQ-010 The engine round and round_key signals SHALL bypass this block and connect directly between the decipher engine and the key memory.

Function
REQ-011 The FSM SHALL have the states IDLE, START, WAIT_BUSY, WAIT_DONE and RESP.
REQ-012 In IDLE the block SHALL assert reqN_ready (combinational) only for the granted valid requester; a handshake occurs when reqN_valid and reqN_ready are both high.
REQ-013 Arbitration SHALL be 2-way round-robin: when both requesters are valid, the grant goes to the requester not served last; when one is valid, it wins; after reset, requester 0 has priority.
REQ-014 On a handshake the block SHALL register block, keylen and id into eng_block, eng_keylen and rsp_id, and go to START.
REQ-015 START SHALL assert eng_next for exactly one cycle, then go to WAIT_BUSY.
REQ-016 WAIT_BUSY SHALL go to WAIT_DONE on the first cycle eng_ready = 0.
REQ-017 WAIT_DONE SHALL, on eng_ready = 1, capture eng_new_block into rsp_block, set rsp_valid = 1 and go to RESP.
REQ-018 eng_block and eng_keylen SHALL be held stable from START until RESP is entered.
REQ-019 RESP SHALL hold rsp_valid, rsp_id, rsp_block and rsp_err stable until rsp_ready = 1, then clear rsp_valid, update the round-robin pointer and go to IDLE.
REQ-020 The block SHALL process only one request at a time, and no reqN_ready SHALL be asserted outside IDLE.
REQ-021 Minimum latency from handshake to rsp_valid SHALL be engine latency + 3 cycles.
REQ-022 A requester SHALL see no request loss when valid is held while the other requester is being served.

Reset
REQ-023 Asserting reset_n low at any time, including mid-operation, SHALL immediately force IDLE, make all outputs 0 (rsp_block = 0, eng_block = 0) and set the round-robin pointer so requester 0 has priority.
REQ-024 An in-flight request SHALL be discarded on reset, with no response produced.

Configuration
REQ-025 With AES_DEC_SCHED_TIMEOUT_EN defined, an 8-bit counter SHALL count the cycles spent in WAIT_BUSY+WAIT_DONE.
REQ-026 With AES_DEC_SCHED_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES the block SHALL enter RESP with rsp_err = 1 and rsp_block = 0; the counter SHALL clear on entry to START.
REQ-027 Without AES_DEC_SCHED_TIMEOUT_EN, the block SHALL have no counter, rsp_err SHALL be constant 0, and WAIT states SHALL wait indefinitely.

Structure
REQ-028 Package aes_dec_sched_pkg SHALL hold the FSM state typedef and the constants AES_128_BIT_KEY = 0 and AES_256_BIT_KEY = 1.
REQ-029 The arbitration SHALL be a sub-module aes_dec_rr_arb2 (inputs: two valids, pointer update strobe; output: one-hot grant).

Verification
REQ-030 req0 with block 69c4e0d86a7b0430d8cdb78070b4c55a, keylen 0, FIPS-197 C.1 round keys -> rsp_block 00112233445566778899aabbccddeeff, rsp_id 0, rsp_err 0.
REQ-031 req1 with block 8ea2b7ca516745bfeafc49904b496089, keylen 1, FIPS-197 C.3 round keys -> rsp_block 00112233445566778899aabbccddeeff, rsp_id 1.
REQ-032 Both requesters valid continuously for 4 requests -> rsp_id sequence 0, 1, 0, 1; no reqN_ready outside IDLE.
REQ-033 rsp_ready held low for 10 cycles -> rsp_valid and rsp_block stable throughout, no new handshake, and eng_next pulses exactly once per request.
REQ-034 reset_n low during WAIT_DONE -> all outputs 0 next sample, busy 0, no response; the next request completes correctly.
REQ-035 With the macro defined and eng_ready stuck at 1 after eng_next -> rsp_valid with rsp_err 1, rsp_block 0, after TIMEOUT_CYCLES (64) cycles.
